adc_packet_sequencer: RTL and testbench

- Sequences ADC channel-group words into the 64-bit AXI4-Stream packet FIFO feeding the C2H XDMA stream, on the data_clk side.
- Opens a packet only when the FIFO reports space (prog_empty).
- On each new_sample strobe, walks all channel groups of a sample buffer and frames fixed-length packets with tlast.
- Pads a partial packet on DMA stop, and counts packets and dropped samples.

---
 rtl/adc_packet_sequencer_if.sv | 25 ++
 rtl/adc_packet_sequencer.sv | 173 +++++++++++++++++
 tb/tb_adc_packet_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_packet_sequencer_if.sv
// AXI4-Stream link from the ADC packet sequencer to the C2H packet FIFO.
interface adc_packet_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 64
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/adc_packet_sequencer.sv
// Frames ADC channel-group words into fixed-length AXI4-Stream packets for the C2H FIFO.
// Optional ADC_PKT_HEADER_EN macro prepends one header word to every packet.
module adc_packet_sequencer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned GRP_WIDTH  = 4,
  parameter int unsigned PKT_WORDS  = 2048,
  parameter int unsigned OVR_WIDTH  = 16
) (
  input  logic                  data_clk,
  input  logic                  user_rstn,
  input  logic                  dma_ena,
  input  logic                  new_sample,
  input  logic                  fifo_prog_empty,
  output logic [GRP_WIDTH-1:0]  smp_grp_addr,
  input  logic [DATA_WIDTH-1:0] smp_grp_data,
  adc_packet_sequencer_if.master m_axis,
  output logic [31:0]           pkt_count,
  output logic [OVR_WIDTH-1:0]  overrun_count,
  output logic                  busy
);

  localparam int unsigned WCNT_WIDTH = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [WCNT_WIDTH-1:0] LAST_WORD = WCNT_WIDTH'(PKT_WORDS - 1);
  localparam logic [GRP_WIDTH-1:0]  LAST_GRP  = '1;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_SAMPLE = 3'd1,
    DATA        = 3'd2,
    PAD         = 3'd3
`ifdef ADC_PKT_HEADER_EN
    , HEADER    = 3'd4
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [WCNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic [GRP_WIDTH-1:0]   grp_q, grp_d;
  logic [31:0]            pkt_count_d;
  logic [OVR_WIDTH-1:0]   overrun_count_d;
  logic                   busy_d;
  logic                   ovr_inc, ovr_clr;
  logic                   tvalid_c, tlast_c;
  logic [DATA_WIDTH-1:0]  tdata_c;

  // State and counter registers
  always_ff @(posedge data_clk or negedge user_rstn) begin
    if (!user_rstn) begin
      state_q       <= IDLE;
      word_cnt_q    <= '0;
      grp_q         <= '0;
      pkt_count     <= '0;
      overrun_count <= '0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      grp_q         <= grp_d;
      pkt_count     <= pkt_count_d;
      overrun_count <= overrun_count_d;
      busy          <= busy_d;
    end
  end

  // Next-state, counter updates and stream decode
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    grp_d       = grp_q;
    pkt_count_d = pkt_count;
    ovr_inc     = 1'b0;
    ovr_clr     = 1'b0;
    tvalid_c    = 1'b0;
    tlast_c     = 1'b0;
    tdata_c     = '0;

    case (state_q)
      IDLE: begin
        word_cnt_d = '0;
        grp_d      = '0;
        if (!dma_ena) begin
          ovr_clr     = 1'b1;
          pkt_count_d = '0;
        end else begin
          ovr_inc = new_sample;
          // Only open a packet when a whole one is guaranteed to fit downstream
          if (fifo_prog_empty) begin
`ifdef ADC_PKT_HEADER_EN
            state_d = HEADER;
`else
            state_d = WAIT_SAMPLE;
`endif
          end
        end
      end

      WAIT_SAMPLE: begin
        grp_d = '0;
        if (new_sample) begin
          state_d = DATA;
        end else if (!dma_ena) begin
          state_d = (word_cnt_q != '0) ? PAD : IDLE;
        end
      end

      DATA: begin
        tvalid_c = 1'b1;
        tdata_c  = smp_grp_data;
        tlast_c  = (word_cnt_q == LAST_WORD);
        ovr_inc  = new_sample;
        if (m_axis.tready) begin
          grp_d = grp_q + GRP_WIDTH'(1);
          if (tlast_c) begin
            word_cnt_d  = '0;
            pkt_count_d = pkt_count + 32'd1;
            state_d     = IDLE;
          end else begin
            word_cnt_d = word_cnt_q + WCNT_WIDTH'(1);
            if (grp_q == LAST_GRP) begin
              state_d = WAIT_SAMPLE;
            end
          end
        end
      end

      PAD: begin
        tvalid_c = 1'b1;
        tlast_c  = (word_cnt_q == LAST_WORD);
        ovr_inc  = new_sample;
        if (m_axis.tready) begin
          if (tlast_c) begin
            word_cnt_d  = '0;
            pkt_count_d = pkt_count + 32'd1;
            state_d     = IDLE;
          end else begin
            word_cnt_d = word_cnt_q + WCNT_WIDTH'(1);
          end
        end
      end

`ifdef ADC_PKT_HEADER_EN
      HEADER: begin
        tvalid_c = 1'b1;
        tdata_c  = DATA_WIDTH'({pkt_count, 16'hA5C0, 16'(PKT_WORDS)});
        ovr_inc  = new_sample;
        if (m_axis.tready) begin
          state_d = WAIT_SAMPLE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

    if (ovr_clr) begin
      overrun_count_d = '0;
    end else if (ovr_inc && (overrun_count != '1)) begin
      overrun_count_d = overrun_count + OVR_WIDTH'(1);
    end else begin
      overrun_count_d = overrun_count;
    end

    busy_d = (state_d != IDLE);
  end

  assign smp_grp_addr  = grp_q;
  assign m_axis.tvalid = tvalid_c;
  assign m_axis.tlast  = tlast_c;
  assign m_axis.tdata  = tdata_c;

endmodule

// File: tb/tb_adc_packet_sequencer.sv
// Self-checking bench for adc_packet_sequencer: directed scenarios plus randomized traffic against a packet-level model.
module tb_adc_packet_sequencer;

  localparam int unsigned DW = 64;
  localparam int unsigned GW = 2;
  localparam int unsigned PW = 8;
  localparam int unsigned OW = 8;
  localparam int unsigned SW = 1 << GW;
  localparam int unsigned OVR_MAX = (1 << OW) - 1;
`ifdef ADC_PKT_HEADER_EN
  localparam int unsigned HDR = 1;
`else
  localparam int unsigned HDR = 0;
`endif
  localparam logic [63:0] HDR_WORD0 = 64'h0000_0000_A5C0_0008;

  logic          data_clk = 1'b0;
  logic          user_rstn = 1'b0;
  logic          dma_ena = 1'b0;
  logic          new_sample = 1'b0;
  logic          fifo_prog_empty = 1'b0;
  logic [GW-1:0] smp_grp_addr;
  logic [DW-1:0] smp_grp_data;
  logic [DW-1:0] buf_base = 64'h100;
  logic [31:0]   pkt_count;
  logic [OW-1:0] overrun_count;
  logic          busy;

  adc_packet_sequencer_if #(.DATA_WIDTH(DW)) axis ();

  adc_packet_sequencer #(
    .DATA_WIDTH(DW), .GRP_WIDTH(GW), .PKT_WORDS(PW), .OVR_WIDTH(OW)
  ) dut (
    .data_clk        (data_clk),
    .user_rstn       (user_rstn),
    .dma_ena         (dma_ena),
    .new_sample      (new_sample),
    .fifo_prog_empty (fifo_prog_empty),
    .smp_grp_addr    (smp_grp_addr),
    .smp_grp_data    (smp_grp_data),
    .m_axis          (axis),
    .pkt_count       (pkt_count),
    .overrun_count   (overrun_count),
    .busy            (busy)
  );

  always #5 data_clk = ~data_clk;

  // Sample buffer: word = base + channel-group index
  assign smp_grp_data = buf_base + DW'(smp_grp_addr);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level model: packet open?, data words sent, words left in sample, padding, header owed
  bit          m_open = 1'b0;
  bit          m_pad  = 1'b0;
  bit          m_hdr  = 1'b0;
  int unsigned m_words = 0;
  int unsigned m_left  = 0;
  logic [31:0] m_pkts  = '0;
  int unsigned m_ovr   = 0;

  function automatic bit m_emitting();
    return m_open && (m_hdr || m_left != 0 || m_pad);
  endfunction

  function automatic bit m_waiting();
    return m_open && !m_hdr && m_left == 0 && !m_pad;
  endfunction

  function automatic logic [GW-1:0] m_addr();
    return (m_open && !m_hdr && m_left != 0) ? GW'(SW - m_left) : '0;
  endfunction

  function automatic logic [63:0] m_data();
    if (m_hdr) return {m_pkts, 16'hA5C0, 16'(PW)};
    if (m_pad) return 64'd0;
    return buf_base + 64'(m_addr());
  endfunction

  function automatic bit m_last();
    return !m_hdr && (m_left != 0 || m_pad) && (m_words == PW - 1);
  endfunction

  task automatic m_drop();
    if (m_ovr < OVR_MAX) m_ovr++;
  endtask

  task automatic m_step();
    bit x;
    x = m_emitting() && axis.tready;
    if (!m_open) begin
      if (!dma_ena) begin
        m_pkts = '0;
        m_ovr  = 0;
      end else begin
        if (new_sample) m_drop();
        if (fifo_prog_empty) begin
          m_open = 1'b1;
          m_hdr  = (HDR != 0);
        end
      end
    end else if (m_hdr) begin
      if (new_sample) m_drop();
      if (x) m_hdr = 1'b0;
    end else if (m_left != 0 || m_pad) begin
      if (new_sample) m_drop();
      if (x) begin
        m_words++;
        if (m_left != 0) m_left--;
        if (m_words == PW) begin
          m_pkts  = m_pkts + 32'd1;
          m_words = 0;
          m_pad   = 1'b0;
          m_open  = 1'b0;
        end
      end
    end else begin
      if (new_sample) m_left = SW;
      else if (!dma_ena) begin
        if (m_words != 0) m_pad = 1'b1;
        else m_open = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge data_clk or negedge user_rstn);
    if (!user_rstn) begin
      m_open = 1'b0; m_pad = 1'b0; m_hdr = 1'b0;
      m_words = 0; m_left = 0; m_pkts = '0; m_ovr = 0;
    end else begin
      m_step();
    end
  end

  logic [63:0] log_data[$];
  bit          log_last[$];

  // Compare every cycle on the falling edge and log accepted words
  initial forever begin
    @(negedge data_clk);
    chk("tvalid", 64'(axis.tvalid), 64'(m_emitting()));
    if (m_emitting()) begin
      chk("tdata", axis.tdata, m_data());
      chk("tlast", 64'(axis.tlast), 64'(m_last()));
    end
    chk("busy", 64'(busy), 64'(m_open));
    chk("smp_grp_addr", 64'(smp_grp_addr), 64'(m_addr()));
    chk("pkt_count", 64'(pkt_count), 64'(m_pkts));
    chk("overrun_count", 64'(overrun_count), 64'(m_ovr));
    if (axis.tvalid && axis.tready) begin
      log_data.push_back(axis.tdata);
      log_last.push_back(axis.tlast);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge data_clk);
      #1;
    end
  endtask

  task automatic strobe();
    new_sample = 1'b1;
    tick(1);
    new_sample = 1'b0;
  endtask

  task automatic wait_for_sample_slot();
    int n;
    n = 0;
    while (!m_waiting() && n < 40) begin
      tick(1);
      n++;
    end
    chk("wait_sample_slot", 64'(m_waiting()), 64'd1);
  endtask

  task automatic clear_log();
    log_data.delete();
    log_last.delete();
  endtask

  initial begin
    axis.tready = 1'b1;
    tick(2);
    chk("rst_tvalid", 64'(axis.tvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pkt", 64'(pkt_count), 64'd0);
    chk("rst_ovr", 64'(overrun_count), 64'd0);
    user_rstn = 1'b1;

    // T1: one full packet from two samples
    clear_log();
    dma_ena = 1'b1; fifo_prog_empty = 1'b1;
    tick(2);
    strobe();
    tick(4);
    strobe();
    tick(4);
    chk("t1_busy_idle", 64'(busy), 64'd0);
    chk("t1_pkt", 64'(pkt_count), 64'd1);
    chk("t1_len", 64'(log_data.size()), 64'(PW + HDR));
    if (log_data.size() == PW + HDR) begin
      if (HDR != 0) chk("t1_hdr", log_data[0], HDR_WORD0);
      for (int i = 0; i < int'(PW); i++) begin
        chk("t1_word", log_data[HDR + i], 64'h100 + 64'(i % SW));
        chk("t1_last", 64'(log_last[HDR + i]), 64'(i == int'(PW) - 1));
      end
    end
    fifo_prog_empty = 1'b0;

    // T2: no FIFO space, sample dropped in IDLE
    dma_ena = 1'b0;
    tick(1);
    dma_ena = 1'b1;
    clear_log();
    strobe();
    tick(1);
    chk("t2_ovr", 64'(overrun_count), 64'd1);
    chk("t2_busy", 64'(busy), 64'd0);
    chk("t2_no_words", 64'(log_data.size()), 64'd0);
    fifo_prog_empty = 1'b1;
    tick(1);
    chk("t2_busy_open", 64'(busy), 64'd1);
    wait_for_sample_slot();

    // T3: back-pressure in the middle of a sample
    clear_log();
    strobe();
    tick(1);
    axis.tready = 1'b0;
    tick(2);
    chk("t3_grp_held", 64'(smp_grp_addr), 64'd1);
    axis.tready = 1'b1;
    tick(3);
    chk("t3_len", 64'(log_data.size()), 64'd4);
    for (int i = 0; i < log_data.size(); i++)
      chk("t3_word", log_data[i], 64'h100 + 64'(i));

    // T4: DMA stop mid-packet pads to full length
    clear_log();
    dma_ena = 1'b0;
    tick(5);
    chk("t4_len", 64'(log_data.size()), 64'd4);
    for (int i = 0; i < log_data.size(); i++) begin
      chk("t4_zero", log_data[i], 64'd0);
      chk("t4_last", 64'(log_last[i]), 64'(i == 3));
    end
    chk("t4_pkt", 64'(pkt_count), 64'd1);
    chk("t4_busy", 64'(busy), 64'd0);
    tick(1);
    chk("t4_pkt_clr", 64'(pkt_count), 64'd0);
    chk("t4_ovr_clr", 64'(overrun_count), 64'd0);

    // T5: strobes every other cycle, then saturation
    dma_ena = 1'b1;
    tick(2);
    for (int k = 0; k < 6; k++) begin
      new_sample = 1'b1;
      tick(1);
      new_sample = 1'b0;
      tick(1);
    end
    chk("t5_ovr", 64'(overrun_count), 64'd4);
    chk("t5_pkt", 64'(pkt_count), 64'd1);
    new_sample = 1'b1;
    tick(400);
    new_sample = 1'b0;
    chk("t5_ovr_sat", 64'(overrun_count), 64'(OVR_MAX));

    // T6: asynchronous reset while streaming
    wait_for_sample_slot();
    strobe();
    tick(1);
    chk("t6_tvalid_pre", 64'(axis.tvalid), 64'd1);
    #2;
    user_rstn = 1'b0;
    #1;
    chk("t6_tvalid", 64'(axis.tvalid), 64'd0);
    chk("t6_tlast", 64'(axis.tlast), 64'd0);
    chk("t6_pkt", 64'(pkt_count), 64'd0);
    chk("t6_ovr", 64'(overrun_count), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    tick(2);
    user_rstn = 1'b1;
    clear_log();
    tick(2);
    strobe();
    tick(1);
    chk("t6_first_len", 64'(log_data.size()), 64'(1 + HDR));
    if (log_data.size() == 1 + HDR) begin
      if (HDR != 0) chk("t6_hdr", log_data[0], HDR_WORD0);
      chk("t6_first_word", log_data[HDR], 64'h100);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      dma_ena         = ($urandom_range(0, 99) < 92);
      fifo_prog_empty = ($urandom_range(0, 99) < 70);
      axis.tready     = ($urandom_range(0, 99) < 75);
      new_sample      = ($urandom_range(0, 99) < 20);
      if (new_sample && m_waiting())
        buf_base = {32'($urandom), 32'($urandom)};
      tick(1);
    end
    new_sample = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
